risc_ctrl_fsm: RTL and testbench
================================

# risc_ctrl_fsm

Multicycle control unit for the 8-bit RISC core; the issuing side of the ALU interface. It fetches 16-bit instructions over a request/acknowledge memory port and decodes them. It drives `alu_control`, `alu_a` and `alu_b` to the ALU, and writes `alu_result` back into an internal 4x8 register file. The ALU itself is purely combinational and sits outside this block.

## Interface
- Parameters
  - `PC_W`, 8: program counter and instruction address width.
- Ports
  - `clk`, in, 1: sole clock, rising edge.
  - `reset`, in, 1: asynchronous, active-high.
  - `imem_req`, out, 1: fetch request.
  - `imem_addr`, out, PC_W: fetch address.
  - `imem_ack`, in, 1: instruction valid.
  - `imem_rdata`, in, 16: instruction word.
  - `alu_control`, out, 3: ALU op code (000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT).
  - `alu_a`, out, 8: ALU operand A.
  - `alu_b`, out, 8: ALU operand B.
  - `alu_result`, in, 8: ALU result, combinational from the ALU outputs.
  - `dbg_sel`, in, 2: register select for debug read.
  - `dbg_data`, out, 8: combinational read of `R[dbg_sel]`.
  - `halted`, out, 1: HALT executed.
  - `illegal`, out, 1: sticky flag, set on undefined opcode.

## Operation
- Instruction format: `[15:12]` opcode, `[11:10]` rd, `[9:8]` rs, `[7:0]` imm. Instructions are two-address, so `R[rd] <= R[rd] op R[rs]`.
- Opcodes:
  - 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR: a=R[rd], b=R[rs].
  - 0x4 NOT: a=R[rd], b=0.
  - 0x5 ADDI: ADD with a=R[rd], b=imm.
  - 0x6 LDI: ADD with a=0, b=imm.
  - 0xF HALT.
  - All others are illegal.
- States: FETCH, DECODE, EXECUTE, HALT.
  - FETCH: `imem_req`=1 and `imem_addr`=pc. On the first edge where `imem_ack`=1, latch `imem_rdata`, set pc <= pc+1 (wraps 0xFF to 0x00), and go to DECODE.
  - DECODE: register `alu_control`, `alu_a` and `alu_b` from the latched instruction and the register file.
    - Legal ALU op: go to EXECUTE.
    - HALT: go to HALT.
    - Illegal opcode: set `illegal`, go to FETCH, no register write.
  - EXECUTE: ALU outputs are stable. At the closing edge, R[rd] <= `alu_result`. Then go to FETCH.
  - HALT: `halted`=1 and `imem_req`=0. The block leaves HALT only on `reset`.
- All 8-bit arithmetic is modulo 256. There is no carry or overflow output.
- Outside EXECUTE, `alu_control`=000, `alu_a`=0 and `alu_b`=0.
- `imem_ack` is ignored when `imem_req`=0.
- Register writes occur only at the EXECUTE edge. A write and a `dbg_data` read of the same register in the same cycle return the old value.

## Timing
- Reset values:
  - state FETCH, pc 0, R0..R3 0.
  - `imem_req` 1, `imem_addr` 0.
  - `alu_control` 000, `alu_a` 0, `alu_b` 0.
  - `halted` 0, `illegal` 0.
- Instruction latency is (fetch wait + 1) + 1 DECODE + 1 EXECUTE, so an ALU op with zero-wait ack takes 3 cycles. Illegal opcode and HALT take 2 cycles.
- `imem_addr` is held stable while `imem_req`=1 and ack is pending.
- If `reset` is asserted mid-instruction, the instruction is abandoned with no register write and all state returns to reset values asynchronously.
- Back-to-back fetches are allowed: the cycle after EXECUTE is FETCH with the new pc.

## Configuration
- Macro: `RISC_CTRL_BRANCH_EN`.
- Defined: opcode 0x7 is BEQZ. In DECODE, if R[rs]==0 then pc <= imm, else pc is unchanged. Next state is FETCH, with no ALU activity and no register write.
- Undefined: 0x7 is illegal and sets `illegal`.

## Structure
- Shared package `risc_pkg`:
  - opcode constants;
  - ALU control encodings (`ALU_ADD`..`ALU_NOT`), shared with the ALU;
  - state enum;
  - instruction field slice constants.
- Sub-module `regfile4x8`: two combinational read ports plus one debug read port, one synchronous write port, async reset to zero.

## Test plan
- Reset, then release: first cycle shows `imem_req`=1, `imem_addr`=0x00, `alu_control`=000, `halted`=0.
- LDI r1,0x0A; LDI r2,0x05; ADD r1,r2:
  - `dbg_data` for r1 = 0x0F;
  - EXECUTE shows `alu_control`=000, `alu_a`=0x0A, `alu_b`=0x05.
- r1=0x05, r2=0x0A, SUB r1,r2 gives r1=0xFB. Then r1=0xF0, NOT r1 gives r1=0x0F. AND/OR of 0x0A,0x05 gives 0x00 and 0x0F.
- Hold `imem_ack` low for 3 cycles:
  - `imem_req` stays 1 with `imem_addr` constant;
  - pc advances exactly once;
  - ack at pc=0xFF wraps the next fetch to 0x00.
- Opcode 0x8 gives `illegal`=1 and all registers unchanged. HALT gives `halted`=1 and `imem_req`=0 for 20 cycles; a reset pulse then clears both flags.
- Assert `reset` during EXECUTE of ADD r1,r2: r1 is unchanged (0 after reset) and state is FETCH at pc 0.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: opcodes, ALU encodings, control states and instruction field positions for the 8-bit RISC core
package risc_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 10;
  localparam int RS_HI = 9;
  localparam int RS_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;
endpackage

// File: rtl/regfile4x8.sv
// regfile4x8: four 8-bit registers, two operand read ports, one debug read port, one synchronous write port
module regfile4x8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  input  logic [1:0] dbg_sel,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic [7:0] dbg_data
);
  logic [7:0] r [4];
  always_ff @(posedge clk or posedge reset)
    if (reset) r <= '{default: 8'h00};
    else if (we) r[waddr] <= wdata;
  assign rdata_a  = r[raddr_a];
  assign rdata_b  = r[raddr_b];
  assign dbg_data = r[dbg_sel];
endmodule

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multicycle fetch/decode/execute control unit driving an external combinational ALU.
// RISC_CTRL_BRANCH_EN turns opcode 0x7 into BEQZ; otherwise 0x7 is illegal.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [2:0]      alu_control,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_result,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data,
  output logic            halted,
  output logic            illegal
);
  state_t state, state_nx;
  logic [15:0] ir;
  logic [PC_W-1:0] pc;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm, rd_val, rs_val, a_nx, b_nx;
  logic [2:0] ctl_nx;
  logic op_alu, op_br, dec_alu;
  assign op  = ir[OP_HI:OP_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign rs  = ir[RS_HI:RS_LO];
  assign imm = ir[IMM_HI:IMM_LO];
  assign op_alu = op <= OP_LDI;
`ifdef RISC_CTRL_BRANCH_EN
  assign op_br = op == OP_BEQZ;
`else
  assign op_br = 1'b0;
`endif
  assign dec_alu   = state == S_DECODE && op_alu;
  assign imem_req  = state == S_FETCH;
  assign imem_addr = pc;
  assign halted    = state == S_HALT;
  regfile4x8 u_rf (
    .clk(clk), .reset(reset), .we(state == S_EXECUTE), .waddr(rd), .wdata(alu_result),
    .raddr_a(rd), .raddr_b(rs), .dbg_sel(dbg_sel),
    .rdata_a(rd_val), .rdata_b(rs_val), .dbg_data(dbg_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == S_FETCH   ? (imem_ack ? S_DECODE : S_FETCH) :
               state == S_DECODE  ? (op_alu ? S_EXECUTE : op == OP_HALT ? S_HALT : S_FETCH) :
               state == S_EXECUTE ? S_FETCH : S_HALT;
    ctl_nx = op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR :
             op == OP_NOT ? ALU_NOT : ALU_ADD;
    a_nx = op == OP_LDI ? 8'h00 : rd_val;
    b_nx = op == OP_NOT ? 8'h00 : (op == OP_ADDI || op == OP_LDI) ? imm : rs_val;
  end
  // ALU drive registers are loaded only on the DECODE->EXECUTE edge, so they read zero elsewhere
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir          <= '0;
      pc          <= '0;
      alu_control <= ALU_ADD;
      alu_a       <= '0;
      alu_b       <= '0;
      illegal     <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_W'(1);
      end
      if (state == S_DECODE && op_br && rs_val == 8'h00) pc <= PC_W'(imm);
      if (state == S_DECODE && !op_alu && !op_br && op != OP_HALT) illegal <= 1'b1;
      alu_control <= dec_alu ? ctl_nx : ALU_ADD;
      alu_a       <= dec_alu ? a_nx : 8'h00;
      alu_b       <= dec_alu ? b_nx : 8'h00;
    end
endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// tb_risc_ctrl_fsm: directed table-driven bench with behavioural instruction memory and ALU
module tb_risc_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [2:0]  alu_control;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;
  logic        halted, illegal;
  logic [15:0] mem [256];
  logic [7:0]  m [4];
  int ack_wait = 0;
  int pend = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] instr;
    int          wt;
    logic [2:0]  ctl;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
  } vec_t;
  vec_t vec [14];

  risc_ctrl_fsm #(.PC_W(8)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase

  always @(negedge clk)
    if (!imem_req) begin
      imem_ack = 1'b0;
      pend = 0;
    end else if (pend >= ack_wait) begin
      imem_ack = 1'b1;
      imem_rdata = mem[imem_addr];
      pend = 0;
    end else begin
      imem_ack = 1'b0;
      pend = pend + 1;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string name);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #0;
      chk(name, {24'd0, dbg_data}, {24'd0, m[r]});
    end
  endtask

  initial begin
    logic [7:0] pc_e;
    vec[0]  = '{16'h640A, 0, 3'd0, 8'h00, 8'h0A, 8'h0A};
    vec[1]  = '{16'h6805, 0, 3'd0, 8'h00, 8'h05, 8'h05};
    vec[2]  = '{16'h0600, 3, 3'd0, 8'h0A, 8'h05, 8'h0F};
    vec[3]  = '{16'h6405, 0, 3'd0, 8'h00, 8'h05, 8'h05};
    vec[4]  = '{16'h680A, 0, 3'd0, 8'h00, 8'h0A, 8'h0A};
    vec[5]  = '{16'h1600, 0, 3'd1, 8'h05, 8'h0A, 8'hFB};
    vec[6]  = '{16'h64F0, 0, 3'd0, 8'h00, 8'hF0, 8'hF0};
    vec[7]  = '{16'h4400, 1, 3'd4, 8'hF0, 8'h00, 8'h0F};
    vec[8]  = '{16'h6405, 0, 3'd0, 8'h00, 8'h05, 8'h05};
    vec[9]  = '{16'h2600, 0, 3'd2, 8'h05, 8'h0A, 8'h00};
    vec[10] = '{16'h6405, 0, 3'd0, 8'h00, 8'h05, 8'h05};
    vec[11] = '{16'h3600, 0, 3'd3, 8'h05, 8'h0A, 8'h0F};
    vec[12] = '{16'h54F5, 0, 3'd0, 8'h0F, 8'hF5, 8'h04};
    vec[13] = '{16'h0100, 0, 3'd0, 8'h00, 8'h04, 8'h04};
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    for (int i = 0; i < 14; i++) mem[i] = vec[i].instr;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    pend = 0;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_ctl", {29'd0, alu_control}, 32'd0);
    chk("rst_ab", {16'd0, alu_a, alu_b}, 32'd0);
    chk("rst_flags", {30'd0, halted, illegal}, 32'd0);
    check_regs("rst_reg");

    pc_e = 8'h00;
    for (int i = 0; i < 14; i++) begin
      ack_wait = vec[i].wt;
      for (int k = 0; k <= vec[i].wt; k++) begin
        chk($sformatf("fetch%0d", i), {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, pc_e});
        step();
      end
      chk($sformatf("decode%0d", i), {20'd0, imem_req, alu_control, alu_a}, 32'd0);
      step();
      dbg_sel = vec[i].instr[11:10];
      #0;
      chk($sformatf("exec%0d", i), {5'd0, alu_control, alu_a, alu_b, 8'd0},
          {5'd0, vec[i].ctl, vec[i].a, vec[i].b, 8'd0});
      chk($sformatf("old%0d", i), {24'd0, dbg_data}, {24'd0, m[vec[i].instr[11:10]]});
      step();
      chk($sformatf("res%0d", i), {24'd0, dbg_data}, {24'd0, vec[i].res});
      m[vec[i].instr[11:10]] = vec[i].res;
      pc_e = pc_e + 8'd1;
    end

    ack_wait = 0;
    chk("ill_pre", {31'd0, illegal}, 32'd0);
    step();
    step();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_next", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h0F});
    check_regs("ill_reg");

    mem[0] = 16'hF000;
    for (int c = 0; c < 2000 && !(imem_req && imem_addr == 8'hFF); c++) step();
    chk("reach_ff", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'hFF});
    ack_wait = 3;
    for (int k = 0; k < 4; k++) begin
      chk("wait_hold", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'hFF});
      step();
    end
    ack_wait = 0;
    chk("wait_dec", {31'd0, imem_req}, 32'd0);
    step();
    chk("wrap", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h00});
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      chk("halt", {30'd0, halted, imem_req}, {30'd0, 1'b1, 1'b0});
      step();
    end

    reset = 1'b1;
    #1;
    chk("halt_rst", {29'd0, halted, illegal, imem_req}, 32'd1);
    chk("halt_rst_addr", {24'd0, imem_addr}, 32'd0);
    mem[0] = 16'h640A;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    step();
    reset = 1'b0;
    pend = 0;
    repeat (6) step();
    step();
    step();
    chk("pre_rst_exec", {5'd0, alu_control, alu_a, alu_b, 8'd0}, {5'd0, 3'd0, 8'h0A, 8'h05, 8'd0});
    reset = 1'b1;
    dbg_sel = 2'd1;
    #1;
    chk("exec_rst_r1", {24'd0, dbg_data}, 32'd0);
    chk("exec_rst_fetch", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h00});
    chk("exec_rst_alu", {13'd0, alu_control, alu_a, alu_b}, 32'd0);
    step();
    chk("exec_rst_r1b", {24'd0, dbg_data}, 32'd0);
    reset = 1'b0;
    check_regs("exec_rst_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
